// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register-file write port among NUM_SRC writeback requesters
// (src0 = ALU, src1 = LSU, src2 = MUL/DIV) with valid/ready handshakes.
// The winning write is captured in a one-stage output register that drives
// the register file and doubles as the decode forwarding source.
// Build option: define WB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer); default build is round-robin.
module wb_port_arbiter #(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wb_en,
   input  logic [NUM_SRC-1:0]          src_valid,
   output logic [NUM_SRC-1:0]          src_ready,
   input  logic [NUM_SRC*ADDR_W-1:0]   src_rd_addr,
   input  logic [NUM_SRC*DATA_W-1:0]   src_rd_data,
   output logic                        rd_we,
   output logic [ADDR_W-1:0]           rd_addr,
   output logic [DATA_W-1:0]           rd_data,
   output logic [1:0]                  grant_id
);

   logic [3:0]        valid4;
   logic [1:0]        cand;
   logic              gnt_any;
   logic [1:0]        gnt_idx;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   logic              rd_we_q,    rd_we_d;
   logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
   logic [DATA_W-1:0] rd_data_q,  rd_data_d;
   logic [1:0]        grant_id_q, grant_id_d;

`ifndef WB_FIXED_PRIO_EN
   logic [1:0]        last_q, last_d;
   logic [2:0]        sum;
`endif

   assign valid4 = 4'(src_valid);

   // Pick the first valid source in scan order; nothing granted when stalled or in reset
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
`ifndef WB_FIXED_PRIO_EN
      sum     = '0;
`endif
      if (wb_en && rst_n) begin
         for (int unsigned k = 0; k < NUM_SRC; k++) begin
`ifdef WB_FIXED_PRIO_EN
            cand = 2'(k);
`else
            // last+1+k stays below 2*NUM_SRC, so one conditional subtract is the modulo
            sum = {1'b0, last_q} + 3'(k) + 3'd1;
            if (sum >= 3'(NUM_SRC)) sum = sum - 3'(NUM_SRC);
            cand = sum[1:0];
`endif
            if (!gnt_any && valid4[cand]) begin
               gnt_any = 1'b1;
               gnt_idx = cand;
            end
         end
      end
   end

   assign src_ready = gnt_any ? (NUM_SRC'(1) << gnt_idx) : '0;

   // Select the granted source's address and data fields
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (32'(gnt_idx) == i) begin
            sel_addr = src_rd_addr[i*ADDR_W +: ADDR_W];
            sel_data = src_rd_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next state of the output register and round-robin pointer
   always_comb begin
      rd_we_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      rd_data_d  = rd_data_q;
      grant_id_d = grant_id_q;
`ifndef WB_FIXED_PRIO_EN
      last_d     = last_q;
`endif
      if (gnt_any) begin
         // x0 writes still consume the slot but never enable the write
         rd_we_d    = (sel_addr != '0);
         rd_addr_d  = sel_addr;
         rd_data_d  = sel_data;
         grant_id_d = gnt_idx;
`ifndef WB_FIXED_PRIO_EN
         last_d     = gnt_idx;
`endif
      end
   end

   // Output register and pointer state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_we_q    <= 1'b0;
         rd_addr_q  <= '0;
         rd_data_q  <= '0;
         grant_id_q <= '0;
`ifndef WB_FIXED_PRIO_EN
         last_q     <= 2'(NUM_SRC - 1);
`endif
      end else begin
         rd_we_q    <= rd_we_d;
         rd_addr_q  <= rd_addr_d;
         rd_data_q  <= rd_data_d;
         grant_id_q <= grant_id_d;
`ifndef WB_FIXED_PRIO_EN
         last_q     <= last_d;
`endif
      end
   end

   assign rd_we    = rd_we_q;
   assign rd_addr  = rd_addr_q;
   assign rd_data  = rd_data_q;
   assign grant_id = grant_id_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (NUM_SRC=3, ADDR_W=5, DATA_W=32).
// Expectations follow WB_FIXED_PRIO_EN when the bench is built with it.
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_en;
   logic [2:0]  src_valid;
   logic [2:0]  src_ready;
   logic [14:0] src_rd_addr;
   logic [95:0] src_rd_data;
   logic        rd_we;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  grant_id;

   int nchk  = 0;
   int nfail = 0;

   wb_port_arbiter #(.NUM_SRC(3), .ADDR_W(5), .DATA_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_en       (wb_en),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .src_rd_addr (src_rd_addr),
      .src_rd_data (src_rd_data),
      .rd_we       (rd_we),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .grant_id    (grant_id)
   );

   always #5 clk = ~clk;

   task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d);
      src_rd_addr[i*5 +: 5]   = a;
      src_rd_data[i*32 +: 32] = d;
   endtask

   // Synchronous-looking reset pulse; leaves time at posedge+2 with rst_n high
   task automatic do_reset();
      rst_n     = 1'b0;
      src_valid = 3'b000;
      wb_en     = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      wb_en     = 1'b1;
      src_valid = 3'b111;
      set_src(0, 5'd1, 32'h11); set_src(1, 5'd2, 32'h22); set_src(2, 5'd3, 32'h33);
      @(posedge clk); #1;
      nchk++; if (src_ready !== 3'b000) begin nfail++; $display("FAIL reset_ready: got %b exp 000", src_ready); end
      nchk++; if (rd_we !== 1'b0)        begin nfail++; $display("FAIL reset_we: got %b exp 0", rd_we); end
      nchk++; if (rd_addr !== 5'd0)      begin nfail++; $display("FAIL reset_addr: got %0d exp 0", rd_addr); end
      nchk++; if (rd_data !== 32'd0)     begin nfail++; $display("FAIL reset_data: got %h exp 0", rd_data); end
      nchk++; if (grant_id !== 2'd0)     begin nfail++; $display("FAIL reset_gid: got %0d exp 0", grant_id); end
      rst_n = 1'b1;
      #1;
      nchk++; if (src_ready !== 3'b001) begin nfail++; $display("FAIL reset_first_grant: got %b exp 001", src_ready); end
      src_valid = 3'b000;
   endtask

   task automatic test_single();
      do_reset();
      set_src(1, 5'd5, 32'hDEADBEEF);
      src_valid = 3'b010;
      #1;
      nchk++; if (src_ready !== 3'b010) begin nfail++; $display("FAIL single_ready: got %b exp 010", src_ready); end
      @(posedge clk); #1;
      src_valid = 3'b000;
      nchk++; if (rd_we !== 1'b1)           begin nfail++; $display("FAIL single_we: got %b exp 1", rd_we); end
      nchk++; if (rd_addr !== 5'd5)         begin nfail++; $display("FAIL single_addr: got %0d exp 5", rd_addr); end
      nchk++; if (rd_data !== 32'hDEADBEEF) begin nfail++; $display("FAIL single_data: got %h exp deadbeef", rd_data); end
      nchk++; if (grant_id !== 2'd1)        begin nfail++; $display("FAIL single_gid: got %0d exp 1", grant_id); end
      @(posedge clk); #1;
      nchk++; if (rd_we !== 1'b0)   begin nfail++; $display("FAIL single_we_after: got %b exp 0", rd_we); end
      nchk++; if (rd_addr !== 5'd5) begin nfail++; $display("FAIL single_addr_hold: got %0d exp 5", rd_addr); end
   endtask

   task automatic test_round_robin();
      logic [2:0]  exp_rdy;
      logic [4:0]  exp_addr;
      logic [1:0]  exp_gid;
      do_reset();
      set_src(0, 5'd1, 32'hA0); set_src(1, 5'd2, 32'hA1); set_src(2, 5'd3, 32'hA2);
      src_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
`ifdef WB_FIXED_PRIO_EN
         exp_gid = 2'd0;
`else
         exp_gid = 2'(c % 3);
`endif
         exp_rdy  = 3'b001 << exp_gid;
         exp_addr = 5'(exp_gid) + 5'd1;
         #1;
         nchk++; if (src_ready !== exp_rdy) begin nfail++; $display("FAIL rr_ready[%0d]: got %b exp %b", c, src_ready, exp_rdy); end
         @(posedge clk); #1;
         nchk++; if (rd_addr !== exp_addr)  begin nfail++; $display("FAIL rr_addr[%0d]: got %0d exp %0d", c, rd_addr, exp_addr); end
         nchk++; if (grant_id !== exp_gid)  begin nfail++; $display("FAIL rr_gid[%0d]: got %0d exp %0d", c, grant_id, exp_gid); end
         nchk++; if (rd_we !== 1'b1)        begin nfail++; $display("FAIL rr_we[%0d]: got %b exp 1", c, rd_we); end
      end
      src_valid = 3'b000;
   endtask

   task automatic test_x0_write();
      do_reset();
      // src0 first so the pointer sits at 0 before the x0 write
      set_src(0, 5'd4, 32'h44);
      src_valid = 3'b001;
      @(posedge clk); #1;
      set_src(2, 5'd0, 32'h1234);
      src_valid = 3'b100;
      #1;
      nchk++; if (src_ready !== 3'b100) begin nfail++; $display("FAIL x0_ready: got %b exp 100", src_ready); end
      @(posedge clk); #1;
      src_valid = 3'b000;
      nchk++; if (rd_we !== 1'b0)       begin nfail++; $display("FAIL x0_we: got %b exp 0", rd_we); end
      nchk++; if (grant_id !== 2'd2)    begin nfail++; $display("FAIL x0_gid: got %0d exp 2", grant_id); end
      nchk++; if (rd_data !== 32'h1234) begin nfail++; $display("FAIL x0_data: got %h exp 1234", rd_data); end
      // Pointer at 2 scans 0 first; had it stayed at 0, src1 would win
      src_valid = 3'b011;
      #1;
      nchk++; if (src_ready !== 3'b001) begin nfail++; $display("FAIL x0_ptr: got %b exp 001", src_ready); end
      src_valid = 3'b000;
   endtask

   task automatic test_stall();
      do_reset();
      set_src(0, 5'd9, 32'hC0FFEE00);
      wb_en     = 1'b0;
      src_valid = 3'b001;
      for (int c = 0; c < 3; c++) begin
         #1;
         nchk++; if (src_ready !== 3'b000) begin nfail++; $display("FAIL stall_ready[%0d]: got %b exp 000", c, src_ready); end
         @(posedge clk); #1;
         nchk++; if (rd_we !== 1'b0)       begin nfail++; $display("FAIL stall_we[%0d]: got %b exp 0", c, rd_we); end
      end
      wb_en = 1'b1;
      #1;
      nchk++; if (src_ready !== 3'b001) begin nfail++; $display("FAIL stall_resume_ready: got %b exp 001", src_ready); end
      @(posedge clk); #1;
      src_valid = 3'b000;
      wb_en     = 1'b0;
      #1;
      // Write already registered is still presented while stalled
      nchk++; if (rd_we !== 1'b1)   begin nfail++; $display("FAIL stall_resume_we: got %b exp 1", rd_we); end
      nchk++; if (rd_addr !== 5'd9) begin nfail++; $display("FAIL stall_resume_addr: got %0d exp 9", rd_addr); end
      wb_en = 1'b1;
   endtask

   task automatic test_reset_midop();
      do_reset();
      set_src(1, 5'd7, 32'h77);
      src_valid = 3'b010;
      @(posedge clk); #1;
      src_valid = 3'b000;
      nchk++; if (rd_we !== 1'b1)   begin nfail++; $display("FAIL mid_we_pre: got %b exp 1", rd_we); end
      nchk++; if (rd_addr !== 5'd7) begin nfail++; $display("FAIL mid_addr_pre: got %0d exp 7", rd_addr); end
      #2 rst_n = 1'b0;
      #1;
      nchk++; if (rd_we !== 1'b0)   begin nfail++; $display("FAIL mid_we_async: got %b exp 0", rd_we); end
      nchk++; if (rd_addr !== 5'd0) begin nfail++; $display("FAIL mid_addr_async: got %0d exp 0", rd_addr); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      // Pointer back at 2 scans 0,1,2 so src1 wins; stale pointer 1 would pick src2
      src_valid = 3'b110;
      #1;
      nchk++; if (src_ready !== 3'b010) begin nfail++; $display("FAIL mid_ptr: got %b exp 010", src_ready); end
      src_valid = 3'b000;
   endtask

   initial begin
      rst_n       = 1'b0;
      wb_en       = 1'b1;
      src_valid   = 3'b000;
      src_rd_addr = '0;
      src_rd_data = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_x0_write();
      test_stall();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port among NUM_SRC writeback requesters: src0 = ALU, src1 = LSU, src2 = MUL/DIV.
- Uses valid/ready handshakes and round-robin arbitration.
- Drives the register file's rd_we/rd_addr/rd_data through a one-stage output register.
- The registered write is also exported as the forwarding source for decode, because a write lands only at the clock edge.

Parameters:
NUM_SRC, 3, number of writeback requesters (2..4)
ADDR_W, 5, register address width
DATA_W, 32, write data width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wb_en  input  1  1 = arbitration enabled; 0 = no grants (pipeline stall)
src_valid  input  NUM_SRC  per-source write request
src_ready  output  NUM_SRC  per-source grant, one-hot or zero
src_rd_addr  input  NUM_SRC*ADDR_W  packed destination addresses; source i at [i*ADDR_W +: ADDR_W]
src_rd_data  input  NUM_SRC*DATA_W  packed write data; source i at [i*DATA_W +: DATA_W]
rd_we  output  1  register-file write enable (registered)
rd_addr  output  ADDR_W  register-file write address (registered)
rd_data  output  DATA_W  register-file write data (registered)
grant_id  output  2  index of the source that produced the current rd_* (registered)

Behaviour:
- Clock/reset: clk only. rst_n is asynchronous and active-low.
- Reset values:
  - rd_we=0, rd_addr=0, rd_data=0, grant_id=0.
  - RR pointer last=NUM_SRC-1, so src0 has top priority first.
  - src_ready=0 while rst_n=0.
- Grant (combinational):
  - When wb_en=1, src_ready has exactly one bit set: the first valid source scanning (last+1), (last+2), ... mod NUM_SRC.
  - When wb_en=0 or no source is valid, src_ready=0.
  - src_ready[i] never asserts without src_valid[i].
- Handshake:
  - A transfer from source i occurs on a clock edge where src_valid[i] & src_ready[i].
  - A source holds valid/addr/data stable until it sees ready.
  - An ungranted source waits with no drop and no limit.
- Latency:
  - A source accepted at edge N appears on rd_* during cycle N..N+1.
  - The register file commits it at edge N+1.
  - Exactly one write per cycle; throughput is 1 accept/cycle.
- Output register:
  - On a transfer: rd_we = (addr != 0), rd_addr/rd_data = the source's fields, grant_id = i.
  - With no transfer: rd_we=0; rd_addr/rd_data/grant_id hold their previous values.
- x0 writes: accepted and granted normally (they consume a slot), but rd_we=0.
- RR pointer: last <= i only on a transfer from i. It is unchanged when wb_en=0 or when nothing is valid.
- Simultaneous requests: losers keep valid. With all 3 valid continuously, grant order is 0,1,2,0,1,2...
- wb_en deassert:
  - src_ready drops in the same cycle.
  - A write already in the output register still commits at the next edge.
- Reset mid-operation: the output register clears immediately (asynchronous), rd_we=0, and any pending in-flight write is lost.
- Unused upper packed fields for NUM_SRC<4: no constraint. grant_id is always < NUM_SRC.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (src0 > src1 > src2); the RR pointer logic is not built.
- Undefined: round-robin as specified above.
- Handshake, latency and x0 rules are identical in both builds.

Test Plan:
- Reset with all src_valid=1 and rst_n=0 -> src_ready=0, rd_we=0, rd_addr=0, rd_data=0. After release, the first grant goes to src0.
- Single request, src1 valid with addr=5, data=0xDEADBEEF, for one cycle -> src_ready=3'b010 that cycle. Next cycle: rd_we=1, rd_addr=5, rd_data=0xDEADBEEF, grant_id=1. The cycle after: rd_we=0.
- All three sources valid for 6 cycles with distinct addrs 1/2/3 -> grants 0,1,2,0,1,2 and rd_addr sequence 1,2,3,1,2,3. Under WB_FIXED_PRIO_EN -> src0 is granted all 6 cycles.
- src2 valid with addr=0, data=0x1234 -> src_ready[2]=1 and it is accepted, but rd_we stays 0. The RR pointer advances to 2.
- Stall: src0 valid with wb_en=0 for 3 cycles -> src_ready=0 and rd_we=0 throughout. When wb_en=1, src0 is granted on the same cycle and the write follows on the next cycle.
- rst_n pulsed low for 1 cycle while rd_we=1 (addr=7) -> rd_we=0 immediately (asynchronous). The RR pointer returns to NUM_SRC-1.
